// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } pwm_state_t;

    localparam int DUTY_SCALE = 1000;
    localparam int DUTY_W     = 10;

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider, one quotient bit per cycle.
// The start cycle already produces the first bit, so a result takes NUM_W cycles.
module pwm_div
    import pwm_pkg::*;
#(
    parameter int NUM_W = 30,
    parameter int DEN_W = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quot
);
    localparam int CW = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] num_q;
    logic [DEN_W-1:0] den_q;
    logic [DEN_W-1:0] rem_q;
    logic [CW-1:0]    cnt_q;

    logic             load;
    logic [NUM_W-1:0] cur_num;
    logic [DEN_W-1:0] cur_den;
    logic [DEN_W-1:0] cur_rem;
    logic [DEN_W:0]   trial;
    logic [DEN_W:0]   diff;
    logic             q_bit;
    logic [DEN_W-1:0] rem_nxt;

    assign load = start && !busy;

    always_comb begin
        cur_num = load ? num : num_q;
        cur_den = load ? den : den_q;
        cur_rem = load ? '0  : rem_q;
        trial   = {cur_rem, cur_num[NUM_W-1]};
        diff    = trial - {1'b0, cur_den};
        q_bit   = (trial >= {1'b0, cur_den});
        rem_nxt = q_bit ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
    end

    // Quotient bits shift in at the bottom of num_q as dividend bits leave the top.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            num_q <= '0;
            den_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                num_q <= {num[NUM_W-2:0], q_bit};
                den_q <= den;
                rem_q <= rem_nxt;
                cnt_q <= CW'(NUM_W - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                num_q <= {num_q[NUM_W-2:0], q_bit};
                rem_q <= rem_nxt;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quot = num_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period / duty capture with stuck-input detection.
// state     | meaning
// WAIT_RISE | no period in progress; counts idle cycles toward the stuck timeout
// MEAS_HIGH | after a rise; counting high time and period
// MEAS_LOW  | after the fall; counting the remainder of the period
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [CNT_W-1:0]  period_cnt,
    output logic [DUTY_W-1:0] duty_permille,
    output logic              meas_valid,
    output logic              meas_drop,
    output logic              level_stuck,
    output logic              stuck_level
);
    localparam int NUM_W = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

    logic sync1, sync2, sync3;
    logic rise, fall;

    pwm_state_t       state_q, state_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
    logic             complete;
    logic             timeout_hit;

    logic [CNT_W-1:0] pend_hi, pend_per;
    logic             div_busy, div_done;
    logic [NUM_W-1:0] div_num, div_quot;

    assign rise = sync2 && !sync3;
    assign fall = !sync2 && sync3;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= WAIT_RISE;
            high_q   <= '0;
            per_q    <= '0;
            hi_lat_q <= '0;
        end else begin
            state_q  <= state_d;
            high_q   <= high_d;
            per_q    <= per_d;
            hi_lat_q <= hi_lat_d;
        end
    end

    // per_q doubles as the idle counter while waiting for a rise.
    always_comb begin
        state_d     = state_q;
        high_d      = high_q;
        per_d       = per_q;
        hi_lat_d    = hi_lat_q;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = MEAS_HIGH;
                    high_d  = ONE;
                    per_d   = ONE;
                end else if (fall) begin
                    per_d = '0;
                end else if (!level_stuck) begin
                    if (per_q >= TO_M1) timeout_hit = 1'b1;
                    else                per_d = per_q + ONE;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    hi_lat_d = high_q;
                    per_d    = per_q + ONE;
                    state_d  = MEAS_LOW;
                end else if (per_q >= TO_C) begin
                    timeout_hit = 1'b1;
                    state_d     = WAIT_RISE;
                    high_d      = '0;
                    per_d       = '0;
                end else begin
                    high_d = high_q + ONE;
                    per_d  = per_q + ONE;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    complete = 1'b1;
                    state_d  = MEAS_HIGH;
                    high_d   = ONE;
                    per_d    = ONE;
                end else if (per_q >= TO_C) begin
                    timeout_hit = 1'b1;
                    state_d     = WAIT_RISE;
                    high_d      = '0;
                    per_d       = '0;
                end else begin
                    per_d = per_q + ONE;
                end
            end
            default: begin
                state_d = WAIT_RISE;
                high_d  = '0;
                per_d   = '0;
            end
        endcase
    end

    assign div_num   = NUM_W'(hi_lat_q) * NUM_W'(DUTY_SCALE);
    assign meas_drop = complete && div_busy;

    pwm_div #(
        .NUM_W(NUM_W),
        .DEN_W(CNT_W)
    ) u_div (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (complete),
        .num      (div_num),
        .den      (per_q),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            sync3         <= 1'b0;
            pend_hi       <= '0;
            pend_per      <= '0;
            high_cnt      <= '0;
            period_cnt    <= '0;
            duty_permille <= '0;
            meas_valid    <= 1'b0;
            level_stuck   <= 1'b0;
            stuck_level   <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            sync3 <= sync2;

            if (timeout_hit) begin
                level_stuck <= 1'b1;
                stuck_level <= sync2;
            end else if (rise || fall) begin
                level_stuck <= 1'b0;
            end

            // Pending values belong to the division in flight; only an accepted start replaces them.
            if (complete && !div_busy) begin
                pend_hi  <= hi_lat_q;
                pend_per <= per_q;
            end

            meas_valid <= div_done;
            if (div_done) begin
                high_cnt      <= pend_hi;
                period_cnt    <= pend_per;
                duty_permille <= (div_quot > NUM_W'(DUTY_SCALE)) ? DUTY_W'(DUTY_SCALE)
                                                                 : div_quot[DUTY_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table-driven PWM patterns, stuck/reset sequences and a
// randomized run, all checked against a period-level reference model.
module tb_pwm_capture;
    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 1000;
    localparam int LAT     = CNT_W + 11;
    localparam int DIV_CYC = CNT_W + 10;
    localparam int NMAX    = 40000;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b1;
    logic             pwm_in    = 1'b0;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic [9:0]       duty_permille;
    logic             meas_valid, meas_drop, level_stuck, stuck_level;

    always #5 sys_clk = ~sys_clk;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pwm_in       (pwm_in),
        .high_cnt     (high_cnt),
        .period_cnt   (period_cnt),
        .duty_permille(duty_permille),
        .meas_valid   (meas_valid),
        .meas_drop    (meas_drop),
        .level_stuck  (level_stuck),
        .stuck_level  (stuck_level)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected events indexed by the negedge count at which they are visible.
    bit exp_v[NMAX];
    bit exp_dr[NMAX];
    int exp_h[NMAX], exp_p[NMAX], exp_d[NMAX];
    int cur_h, cur_p, cur_d;
    bit lvl;
    int last_rise, fall_t, last_acc, n_exp_v, n_exp_dr;
    bit chk_stuck;
    int obs_h[$], obs_p[$], obs_d[$];
    int n_drop_obs;

    typedef struct {
        int hi; int lo; int reps;
        int e_h; int e_p; int e_d; int e_nv; int e_nd;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // A rise completes the period started by the previous rise; the divider
    // accepts it only when the last accepted start is DIV_CYC or more cycles back.
    task automatic model(input bit v);
        int hi, per;
        if (sys_rst_n && v && !lvl) begin
            if (last_rise >= 0 && cyc + LAT + 2 < NMAX) begin
                hi  = fall_t - last_rise;
                per = cyc - last_rise;
                if (cyc - last_acc >= DIV_CYC) begin
                    exp_v[cyc+LAT+2] = 1'b1;
                    exp_h[cyc+LAT+2] = hi;
                    exp_p[cyc+LAT+2] = per;
                    exp_d[cyc+LAT+2] = (hi * 1000) / per;
                    last_acc = cyc;
                    n_exp_v++;
                end else begin
                    exp_dr[cyc+2] = 1'b1;
                    n_exp_dr++;
                end
            end
            last_rise = cyc;
        end
        if (sys_rst_n && !v && lvl) fall_t = cyc;
        lvl = v;
    endtask

    task automatic step(input bit v);
        @(negedge sys_clk);
        if (cyc >= NMAX - LAT - 4) begin
            $display("FAIL cycle_budget at cycle %0d: got %0d expected below %0d", cyc, cyc, NMAX - LAT - 4);
            $fatal(1, "cycle budget exceeded");
        end
        if (exp_v[cyc] || meas_valid) check("meas_valid", meas_valid, exp_v[cyc]);
        if (exp_dr[cyc] || meas_drop) check("meas_drop", meas_drop, exp_dr[cyc]);
        if (exp_v[cyc]) begin
            cur_h = exp_h[cyc];
            cur_p = exp_p[cyc];
            cur_d = exp_d[cyc];
        end
        if (exp_v[cyc] || (cyc % 8) == 0) begin
            check("high_cnt", high_cnt, cur_h);
            check("period_cnt", period_cnt, cur_p);
            check("duty_permille", duty_permille, cur_d);
        end
        if (chk_stuck && (cyc % 8) == 0) check("level_stuck_idle", level_stuck, 0);
        if (meas_valid) begin
            obs_h.push_back(int'(high_cnt));
            obs_p.push_back(int'(period_cnt));
            obs_d.push_back(int'(duty_permille));
        end
        if (meas_drop) n_drop_obs++;
        pwm_in = v;
        model(v);
        cyc++;
    endtask

    task automatic clear_obs();
        obs_h.delete(); obs_p.delete(); obs_d.delete();
        n_drop_obs = 0; n_exp_v = 0; n_exp_dr = 0;
    endtask

    task automatic do_reset(input bit v);
        sys_rst_n = 1'b0;
        pwm_in    = v;
        #1;
        check("rst_high_cnt", high_cnt, 0);
        check("rst_period_cnt", period_cnt, 0);
        check("rst_duty", duty_permille, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_stuck", level_stuck, 0);
        check("rst_stuck_level", stuck_level, 0);
        for (int i = cyc; i < NMAX; i++) begin
            exp_v[i]  = 1'b0;
            exp_dr[i] = 1'b0;
        end
        cur_h = 0; cur_p = 0; cur_d = 0;
        last_rise = -1; fall_t = 0; last_acc = -100000; lvl = v;
        chk_stuck = 1'b0;
        clear_obs();
        repeat (3) step(v);
        sys_rst_n = 1'b1;
    endtask

    task automatic run_pwm(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            repeat (hi) step(1'b1);
            repeat (lo) step(1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    initial begin
        int n0;
        vecs[0] = '{30, 70, 4, 30, 100, 300, 3, 0};
        vecs[1] = '{99,  1, 4, 99, 100, 990, 3, 0};
        vecs[2] = '{ 5, 15, 8,  5,  20, 250, 4, 3};
        vecs[3] = '{ 1, 99, 3,  1, 100,  10, 2, 0};
        vecs[4] = '{50, 50, 3, 50, 100, 500, 2, 0};
        vecs[5] = '{ 7,200, 3,  7, 207,  33, 2, 0};
        vecs[6] = '{17, 13, 5, 17,  30, 566, 4, 0};

        for (int k = 0; k < 7; k++) begin
            do_reset(1'b0);
            idle(5);
            chk_stuck = 1'b1;
            run_pwm(vecs[k].hi, vecs[k].lo, vecs[k].reps);
            idle(40);
            check("tbl_valid_count", obs_h.size(), vecs[k].e_nv);
            check("tbl_drop_count", n_drop_obs, vecs[k].e_nd);
            for (int j = 0; j < obs_h.size(); j++) begin
                check("tbl_high", obs_h[j], vecs[k].e_h);
                check("tbl_period", obs_p[j], vecs[k].e_p);
                check("tbl_duty", obs_d[j], vecs[k].e_d);
            end
        end

        // Input held high from reset: stuck high, never a measurement.
        do_reset(1'b1);
        repeat (950) step(1'b1);
        check("hi_stuck_early", level_stuck, 0);
        repeat (110) step(1'b1);
        check("hi_stuck_set", level_stuck, 1);
        check("hi_stuck_level", stuck_level, 1);
        step(1'b0); step(1'b0); step(1'b0);
        check("hi_stuck_hold", level_stuck, 1);
        step(1'b0);
        check("hi_stuck_clear", level_stuck, 0);
        check("hi_no_valid", obs_h.size(), 0);

        // Idle low after reset: stuck low, cleared by the next rise.
        do_reset(1'b0);
        repeat (950) step(1'b0);
        check("idle_stuck_early", level_stuck, 0);
        repeat (100) step(1'b0);
        check("idle_stuck_set", level_stuck, 1);
        check("idle_stuck_level", stuck_level, 0);
        step(1'b1); step(1'b1); step(1'b1);
        check("idle_stuck_hold", level_stuck, 1);
        step(1'b1);
        check("idle_stuck_clear", level_stuck, 0);
        run_pwm(20, 30, 3);
        idle(40);
        check("idle_valid_count", obs_h.size(), n_exp_v);

        // Stuck low in mid-measurement: partial period discarded, outputs kept.
        do_reset(1'b0);
        idle(5);
        chk_stuck = 1'b1;
        run_pwm(30, 70, 3);
        n0 = cyc;
        repeat (10) step(1'b1);
        chk_stuck = 1'b0;
        while (cyc <= n0 + 1000) step(1'b0);
        check("low_stuck_early", level_stuck, 0);
        while (cyc <= n0 + 1010) step(1'b0);
        check("low_stuck_set", level_stuck, 1);
        check("low_stuck_level", stuck_level, 0);
        check("low_keep_high", high_cnt, 30);
        check("low_keep_period", period_cnt, 100);
        check("low_keep_duty", duty_permille, 300);
        last_rise = -1;
        step(1'b1); step(1'b1); step(1'b1);
        check("low_stuck_hold", level_stuck, 1);
        step(1'b1);
        check("low_stuck_clear", level_stuck, 0);
        run_pwm(30, 70, 2);
        idle(40);
        check("low_valid_count", obs_h.size(), n_exp_v);

        // Reset in MEAS_LOW while dividing: no stale result, two rises needed.
        do_reset(1'b0);
        idle(5);
        chk_stuck = 1'b1;
        run_pwm(10, 90, 3);
        repeat (10) step(1'b1);
        repeat (10) step(1'b0);
        do_reset(1'b0);
        idle(5);
        chk_stuck = 1'b1;
        repeat (10) step(1'b1);
        repeat (90) step(1'b0);
        check("rst_no_early_valid", obs_h.size(), 0);
        run_pwm(10, 90, 2);
        idle(40);
        check("rst_valid_count", obs_h.size(), 2);

        // Randomized phases against the reference model.
        do_reset(1'b0);
        idle(5);
        chk_stuck = 1'b1;
        repeat (150) run_pwm($urandom_range(1, 60), $urandom_range(1, 60), 1);
        idle(40);
        check("rand_valid_count", obs_h.size(), n_exp_v);
        check("rand_drop_count", n_drop_obs, n_exp_dr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
